// File: rtl/freq_div_prog_if.sv
// Divisor load handshake for freq_div_prog: the master offers div_in/div_valid,
// the divider answers with div_ready.
interface freq_div_prog_if #(
    parameter int WIDTH = 16
);
    logic [WIDTH-1:0] div_in;
    logic             div_valid;
    logic             div_ready;

    modport master (output div_in, output div_valid, input  div_ready);
    modport slave  (input  div_in, input  div_valid, output div_ready);
endinterface

// File: rtl/freq_div_prog.sv
// Runtime-programmable clock divider: divided square wave, period-start tick, divisor via valid/ready.
// Define FREQ_DIV_GLITCHLESS_EN to defer divisor loads to the next period wrap instead of restarting.
module freq_div_prog #(
    parameter int WIDTH       = 16,
    parameter int DEFAULT_DIV = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    freq_div_prog_if.slave   div_bus,
    output logic             frequency,
    output logic             tick,
    output logic [WIDTH-1:0] cur_div
);
    localparam logic [WIDTH-1:0] ZERO  = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] ONE   = WIDTH'(32'd1);
    localparam logic [WIDTH-1:0] TWO   = WIDTH'(32'd2);
    localparam logic [WIDTH-1:0] DEF_N = WIDTH'(DEFAULT_DIV);

    typedef enum logic [1:0] {
        LD_NONE    = 2'd0,
        LD_RESTART = 2'd1,
        LD_STOPPED = 2'd2
    } load_mode_e;

    // A divisor of 1 cannot form a square wave, so it is promoted to 2
    function automatic logic [WIDTH-1:0] clamp_div(input logic [WIDTH-1:0] d);
        logic [WIDTH-1:0] r;
        if (d == ONE) begin
            r = TWO;
        end else begin
            r = d;
        end
        return r;
    endfunction

    // ceil(n/2) without the overflow that n+1 would hit at n = 2^WIDTH-1
    function automatic logic [WIDTH-1:0] high_len(input logic [WIDTH-1:0] n);
        return (n >> 1) + {{(WIDTH-1){1'b0}}, n[0]};
    endfunction

    logic [WIDTH-1:0] cnt_r;
    logic [WIDTH-1:0] n_r;
    logic             freq_r;
    logic             tick_r;
    logic             ready_r;

    logic [WIDTH-1:0] cnt_nx_s;
    logic [WIDTH-1:0] n_nx_s;
    logic             freq_nx_s;
    logic             tick_nx_s;
    logic             ready_nx_s;

    logic [WIDTH-1:0] cnt_inc_s;
    logic [WIDTH-1:0] cnt_step_s;
    logic             freq_step_s;
    logic             tick_step_s;
    logic             last_s;
    logic             accept_s;
    logic [WIDTH-1:0] new_n_s;
    load_mode_e       load_mode_s;
    logic [WIDTH-1:0] load_val_s;

    assign last_s   = (cnt_r == (n_r - ONE));
    assign accept_s = div_bus.div_valid && ready_r;
    assign new_n_s  = clamp_div(div_bus.div_in);

    // Free-running count step with no divisor load involved
    always_comb begin
        cnt_inc_s = last_s ? ZERO : (cnt_r + ONE);
        if (n_r == ZERO) begin
            cnt_step_s  = ZERO;
            freq_step_s = 1'b0;
            tick_step_s = 1'b0;
        end else if (en) begin
            cnt_step_s  = cnt_inc_s;
            freq_step_s = (cnt_inc_s < high_len(n_r));
            tick_step_s = (cnt_inc_s == ZERO);
        end else begin
            cnt_step_s  = cnt_r;
            freq_step_s = freq_r;
            tick_step_s = 1'b0;
        end
    end

`ifdef FREQ_DIV_GLITCHLESS_EN
    logic             pend_r;
    logic             pend_nx_s;
    logic [WIDTH-1:0] pend_val_r;
    logic [WIDTH-1:0] pend_val_nx_s;
    logic             wrap_s;

    assign wrap_s = en && (n_r != ZERO) && last_s;

    // Load now (wrap edge or stopped), park the divisor until the wrap, or just count
    always_comb begin
        load_mode_s   = LD_NONE;
        load_val_s    = new_n_s;
        pend_nx_s     = pend_r;
        pend_val_nx_s = pend_val_r;
        if (pend_r && wrap_s) begin
            load_mode_s = LD_RESTART;
            load_val_s  = pend_val_r;
            pend_nx_s   = 1'b0;
        end else if (accept_s && (n_r == ZERO)) begin
            load_mode_s = LD_STOPPED;
        end else if (accept_s && wrap_s) begin
            load_mode_s = LD_RESTART;
        end else if (accept_s) begin
            pend_nx_s     = 1'b1;
            pend_val_nx_s = new_n_s;
        end else begin
            load_mode_s = LD_NONE;
        end
        ready_nx_s = ~pend_nx_s;
    end

    // Pending divisor storage
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pend_r     <= 1'b0;
            pend_val_r <= ZERO;
        end else begin
            pend_r     <= pend_nx_s;
            pend_val_r <= pend_val_nx_s;
        end
    end
`else
    // Every accepted divisor takes effect on the accept edge
    always_comb begin
        load_mode_s = LD_NONE;
        load_val_s  = new_n_s;
        ready_nx_s  = 1'b1;
        if (accept_s && (n_r == ZERO)) begin
            load_mode_s = LD_STOPPED;
        end else if (accept_s) begin
            load_mode_s = LD_RESTART;
        end else begin
            load_mode_s = LD_NONE;
        end
    end
`endif

    // Merge load action with the count step; a load out of the stopped state
    // parks cnt at N-1 so the next enabled edge starts the period like after reset
    always_comb begin
        n_nx_s    = n_r;
        cnt_nx_s  = cnt_step_s;
        freq_nx_s = freq_step_s;
        tick_nx_s = tick_step_s;
        case (load_mode_s)
            LD_RESTART: begin
                n_nx_s    = load_val_s;
                cnt_nx_s  = ZERO;
                freq_nx_s = (load_val_s != ZERO);
                tick_nx_s = (load_val_s != ZERO);
            end
            LD_STOPPED: begin
                n_nx_s    = load_val_s;
                cnt_nx_s  = (load_val_s != ZERO) ? (load_val_s - ONE) : ZERO;
                freq_nx_s = 1'b0;
                tick_nx_s = 1'b0;
            end
            default: begin
                n_nx_s = n_r;
            end
        endcase
    end

    // Divider state and registered outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_r   <= DEF_N - ONE;
            n_r     <= DEF_N;
            freq_r  <= 1'b0;
            tick_r  <= 1'b0;
            ready_r <= 1'b1;
        end else begin
            cnt_r   <= cnt_nx_s;
            n_r     <= n_nx_s;
            freq_r  <= freq_nx_s;
            tick_r  <= tick_nx_s;
            ready_r <= ready_nx_s;
        end
    end

    assign frequency         = freq_r;
    assign tick              = tick_r;
    assign cur_div           = n_r;
    assign div_bus.div_ready = ready_r;

endmodule

// File: tb/tb_freq_div_prog.sv
// Scoreboard bench for freq_div_prog: a period-position reference model predicts every
// clock's outputs; a monitor pops and compares them after each rising edge.
module tb_freq_div_prog;
    localparam int WIDTH       = 16;
    localparam int DEFAULT_DIV = 4;
`ifdef FREQ_DIV_GLITCHLESS_EN
    localparam bit GLITCHLESS = 1'b1;
`else
    localparam bit GLITCHLESS = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             reset;
    logic             en;
    logic             frequency;
    logic             tick;
    logic [WIDTH-1:0] cur_div;

    freq_div_prog_if #(.WIDTH(WIDTH)) div_if ();

    freq_div_prog #(.WIDTH(WIDTH), .DEFAULT_DIV(DEFAULT_DIV)) dut (
        .clk       (clk),
        .reset     (reset),
        .en        (en),
        .div_bus   (div_if),
        .frequency (frequency),
        .tick      (tick),
        .cur_div   (cur_div)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit f;
        bit t;
        int cd;
        bit rdy;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;

    // Reference model: N, position inside the period (-1 = waiting for first edge)
    int m_n;
    int m_pos;
    int m_pv;
    bit m_pend;
    bit m_tick;

    task automatic chk(input string nm, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s actual=%0d required=%0d time=%0t", nm, act, req, $time);
        end
    endtask

    function automatic exp_t m_expect();
        exp_t e;
        e.f   = (m_n != 0) && (m_pos >= 0) && (2 * m_pos < m_n);
        e.t   = m_tick;
        e.cd  = m_n;
        e.rdy = !m_pend;
        return e;
    endfunction

    task automatic m_reset();
        m_n    = DEFAULT_DIV;
        m_pos  = -1;
        m_pend = 1'b0;
        m_pv   = 0;
        m_tick = 1'b0;
    endtask

    task automatic m_start(input int c);
        m_n    = c;
        m_pos  = 0;
        m_tick = (c != 0);
    endtask

    task automatic m_step(input bit e, input bit v, input int d);
        int c;
        bit acc;
        bit wrap;
        c      = (d == 1) ? 2 : d;
        acc    = v && !m_pend;
        wrap   = e && (m_n != 0) && ((m_pos == -1) || (m_pos == m_n - 1));
        m_tick = 1'b0;
        if (GLITCHLESS && m_pend && wrap) begin
            m_start(m_pv);
            m_pend = 1'b0;
        end else if (acc && m_n == 0) begin
            m_n   = c;
            m_pos = -1;
        end else if (acc && (!GLITCHLESS || wrap)) begin
            m_start(c);
        end else begin
            if (acc) begin
                m_pend = 1'b1;
                m_pv   = c;
            end
            if (m_n != 0 && e) begin
                m_pos  = (m_pos + 1) % m_n;
                m_tick = (m_pos == 0);
            end
        end
    endtask

    task automatic check_now(input string tag);
        exp_t e;
        e = m_expect();
        chk({tag, "_freq"},  int'(frequency),         int'(e.f));
        chk({tag, "_tick"},  int'(tick),              int'(e.t));
        chk({tag, "_div"},   int'(cur_div),           e.cd);
        chk({tag, "_ready"}, int'(div_if.div_ready),  int'(e.rdy));
    endtask

    // One clock of stimulus; the expected post-edge outputs go to the scoreboard
    task automatic cyc(input bit rst_low, input bit e, input bit v, input int d);
        bit was_running;
        @(negedge clk);
        en               = e;
        div_if.div_valid = v;
        div_if.div_in    = d[WIDTH-1:0];
        if (rst_low) begin
            was_running = reset;
            reset       = 1'b0;
            m_reset();
            if (was_running) begin
                #1;
                check_now("async_reset");
            end
        end else begin
            reset = 1'b1;
            m_step(e, v, d);
        end
        exp_q.push_back(m_expect());
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 1'b1, 1'b0, 0);
    endtask

    task automatic load(input int d);
        for (int i = 0; i < 40 && m_pend; i++) cyc(1'b0, 1'b1, 1'b0, 0);
        cyc(1'b0, 1'b1, 1'b1, d);
    endtask

    task automatic run_to_pos(input int p);
        for (int i = 0; i < 40 && !(m_pos == p && !m_pend); i++) cyc(1'b0, 1'b1, 1'b0, 0);
    endtask

    // Monitor: compare the DUT against each queued expectation just after the edge
    initial begin
        exp_t got;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                got = exp_q.pop_front();
                chk("frequency", int'(frequency),        int'(got.f));
                chk("tick",      int'(tick),             int'(got.t));
                chk("cur_div",   int'(cur_div),          got.cd);
                chk("div_ready", int'(div_if.div_ready), int'(got.rdy));
            end
        end
    end

    initial begin
        int d;
        bit rs;
        bit e;
        bit v;
        reset            = 1'b0;
        en               = 1'b0;
        div_if.div_valid = 1'b0;
        div_if.div_in    = '0;
        m_reset();
        for (int i = 0; i < 5; i++) cyc(1'b1, 1'b0, 1'b0, 0);
        run(12);
        load(5);
        run(12);
        load(1);
        run(6);
        load(4);
        run(4);
        run_to_pos(1);
        cyc(1'b0, 1'b1, 1'b1, 8);
        run(20);
        run_to_pos(1);
        for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 1'b0, 0);
        run(20);
        load(0);
        for (int i = 0; i < 10; i++) cyc(1'b0, i[0], 1'b0, 0);
        cyc(1'b0, 1'b0, 1'b1, 3);
        run(10);
        run_to_pos(0);
        cyc(1'b0, 1'b1, 1'b1, 6);
        cyc(1'b1, 1'b1, 1'b0, 0);
        cyc(1'b1, 1'b1, 1'b0, 0);
        run(10);
        for (int i = 0; i < 2500; i++) begin
            rs = ($urandom_range(0, 399) == 0);
            e  = ($urandom_range(0, 99) < 85);
            v  = ($urandom_range(0, 19) == 0);
            if ($urandom_range(0, 9) == 0) d = int'($urandom_range(0, 40));
            else d = int'($urandom_range(0, 9));
            cyc(rs, e, v, d);
        end
        run(3);
        @(posedge clk);
        #2;
        chk("queue_drained", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/freq_div_prog.md
# freq_div_prog

Runtime-programmable clock divider generating a divided square wave and a one-cycle period-start strobe from the system clock. It is the parametrised successor of the fixed divider: divisor width is a parameter, the divisor is loaded through a valid/ready handshake, and counting can be paused. It sits beside the fixed divider in the clocking/timebase logic and feeds blinkers, baud timers and sampling enables.

## Interface
- WIDTH, 16, divisor and counter width (≥2)
- DEFAULT_DIV, 4, divisor in force after reset (2 ≤ DEFAULT_DIV < 2^WIDTH)
- clk  input  1  system clock, all logic on rising edge
- reset  input  1  asynchronous, active-low reset (0 = reset asserted)
- en  input  1  count enable; 0 freezes counter and outputs
- div_in  input  WIDTH  new divisor N
- div_valid  input  1  div_in valid
- div_ready  output  1  block can accept a divisor this cycle
- frequency  output  1  divided output, registered
- tick  output  1  one-cycle pulse on the edge where a period starts, registered
- cur_div  output  WIDTH  divisor currently in force

## Operation
- Reset values: cnt = DEFAULT_DIV−1, N = DEFAULT_DIV, frequency = 0, tick = 0, div_ready = 1, cur_div = DEFAULT_DIV, pending flag clear.
- Divisor accepted when div_valid && div_ready on a rising edge; en does not gate acceptance.
- Clamping on accept: div_in = 1 is stored as 2; div_in = 0 is stored as 0 (stopped).
- Counting (en=1, N≥2): cnt_next = (cnt == N−1) ? 0 : cnt+1; cnt <= cnt_next; frequency <= (cnt_next < HI) with HI = ceil(N/2); tick <= (cnt_next == 0).
- Period is exactly N enabled cycles: high HI cycles, low N−HI cycles (N even: 50%; N odd: high one cycle longer).
- First enabled edge after reset wraps cnt to 0: frequency rises and tick pulses on that edge.
- en=0: cnt, frequency, N hold; tick forced 0.
- Stopped (N=0): cnt held 0, frequency 0, tick 0 regardless of en.
- Load behaviour depends on FREQ_DIV_GLITCHLESS_EN (see Configuration).
- Width: counter arithmetic is WIDTH-bit unsigned; cnt never exceeds N−1 so no overflow; maximum divisor 2^WIDTH−1.

## Timing
- Latency from enabled edge to frequency/tick change: 0 extra cycles (outputs registered on the counting edge).
- div_ready is a registered function of the pending flag only; no combinational path from div_valid.
- cur_div updates on the same edge the new N takes effect.
- Reset assertion mid-period: all outputs return to reset values immediately (asynchronous); counting resumes from the reset state on the first edge after release.
- Accept while stopped (N=0) of a nonzero value: applied on the accept edge in both modes; next enabled edge starts a period (cnt=0, frequency=1, tick=1).

## Configuration
- FREQ_DIV_GLITCHLESS_EN defined: accepted divisor held in a pending register, div_ready = 0 while pending; applied at the next wrap edge (cnt == N−1, en=1), which then starts a period of the new N; accept coinciding with a wrap edge applies immediately on that edge without entering pending. Current period never truncated or stretched.
- Not defined: div_ready constant 1; on the accept edge N <= new value, cnt <= 0, frequency <= 1, tick <= 1 (if new N≠0), i.e. period restarts immediately, current period truncated.

## Test plan
- Reset low 5 cycles, release, en=1, DEFAULT_DIV=4 -> frequency 1,1,0,0 repeating; tick on first edge and every 4th edge; cur_div = 4.
- Load N=5 -> high 3 cycles, low 2 cycles, tick every 5 cycles; load N=1 -> cur_div = 2, period 2.
- GLITCHLESS_EN: load N=8 at cnt=1 of N=4 period -> div_ready 0 for 2 cycles, old period completes, new 8-cycle period starts at wrap, tick there; without macro: restart on accept edge, tick same edge.
- en=0 for 3 cycles mid-high phase -> frequency held 1, tick 0, period resumes and totals N enabled cycles.
- Load N=0 -> frequency 0, tick 0 indefinitely; then load N=3 -> next enabled edge frequency 1 and tick 1, period 3 (high 2, low 1).
- Assert reset mid-period with pending load -> frequency 0, tick 0, div_ready 1, cur_div = DEFAULT_DIV immediately; pending value discarded.
